timer_multi_channel: RTL and testbench
======================================

TIMER_MULTI_CHANNEL -- requirements
Module: timer_multi_channel

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 SHALL have parameter PRESC_W, default 8, prescaler width in bits.
REQ-004 SHALL have parameter DEFAULT_PERIOD, default 49999, reset value of every period and counter.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port reset, input, 1; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port address, input, clog2(NUM_CH)+2, {channel, word offset}.
REQ-008 SHALL have ports chipselect, input, 1, and write_n, input, 1 (write when chipselect & ~write_n).
REQ-009 SHALL have port writedata, input, 32, and readdata, output, 32, registered.
REQ-010 SHALL have port irq, output, NUM_CH, per-channel interrupt; plus irq_any, output, 1, OR of irq.

Function
REQ-011 Per-channel word map SHALL be: 0 status {running, timeout}, 1 control {stop, start, cont, ie}, 2 period[CNT_W-1:0], 3 prescale[PRESC_W-1:0] in bits PRESC_W-1:0 and snapshot in reads. Reading word 3 SHALL return the snapshot; writing word 3 SHALL set prescale and capture the snapshot.
REQ-012 Reads SHALL have 1-cycle latency; unmapped/unused bits SHALL read 0; address channel >= NUM_CH SHALL read 0 and ignore writes.
REQ-013 Prescaler SHALL count 0..prescale; tick asserts on the cycle it wraps; prescale=0 SHALL tick every cycle.
REQ-014 Running counter SHALL decrement by 1 per tick; on a tick at 0 it SHALL reload period.
REQ-015 Timeout event SHALL be the rising edge of counter==0; it SHALL set the sticky timeout bit.
REQ-016 With cont=0, counter reaching 0 SHALL clear running; counter holds 0.
REQ-017 Write to status SHALL clear timeout; if a timeout event occurs the same cycle, timeout SHALL remain 1.
REQ-018 Control write with start=1 SHALL set running and reset the prescaler; start and stop both 1 SHALL give running=1.
REQ-019 Period write SHALL, on the next cycle, load counter with the new period, clear prescaler and clear running.
REQ-020 irq[n] SHALL equal timeout[n] & ie[n], combinational from registers.
REQ-021 Period=0 SHALL hold counter at 0 and raise timeout once per start.
REQ-022 Channels SHALL be fully independent; a write to one SHALL not alter another.

Reset
REQ-023 Reset SHALL set counter and period to DEFAULT_PERIOD, prescale, snapshot, control, timeout, running, readdata to 0; irq and irq_any SHALL be 0.
REQ-024 Reset asserted mid-count SHALL return all state to reset values immediately, independent of clk.

Structure
REQ-025 Package timer_multi_channel_pkg SHALL hold word offsets (STATUS, CONTROL, PERIOD, PRESC_SNAP) and control/status bit positions.
REQ-026 Sub-module timer_channel SHALL implement one channel (prescaler, counter, flags, registers); top SHALL instantiate NUM_CH copies plus decode and read mux.

Verification
REQ-027 Ch0 period=4, prescale=0, cont=1, ie=1, start -> timeout/irq[0] at cycles 5 and 10 after start, irq_any=1.
REQ-028 Ch1 period=3, prescale=2, cont=0, start -> counter decrements every 3 cycles, running=0 and timeout=1 after 12 cycles; ch0 unaffected.
REQ-029 Status clear written same cycle as timeout event -> timeout stays 1.
REQ-030 Period write 10 while running -> next cycle counter=10, running=0; snapshot write then read word 3 -> 10.
REQ-031 Reset asserted mid-count -> counter=49999, irq=0 without clk edge.
REQ-032 Control write start=1, stop=1 -> running=1; read address of channel >= NUM_CH -> 0.

Source files
------------

// File: rtl/timer_multi_channel_pkg.sv
// Shared definitions for the multi-channel interval timer.
//
// Per-channel register word offsets (address[1:0]) and bit positions
// inside the status and control words.
package timer_multi_channel_pkg;

   localparam logic [1:0] STATUS     = 2'd0;
   localparam logic [1:0] CONTROL    = 2'd1;
   localparam logic [1:0] PERIOD     = 2'd2;
   localparam logic [1:0] PRESC_SNAP = 2'd3;

   // status word
   localparam int ST_TIMEOUT = 0;
   localparam int ST_RUNNING = 1;

   // control word
   localparam int CTL_IE    = 0;
   localparam int CTL_CONT  = 1;
   localparam int CTL_START = 2;
   localparam int CTL_STOP  = 3;

endpackage

// File: rtl/timer_channel.sv
// One interval-timer channel: prescaler, down-counter, sticky timeout flag
// and its four-word register block.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   i_wr_en      write strobe already qualified for this channel
//   i_offset     word offset within the channel
//   i_wdata      write data
//   o_rdata      combinational read value of the addressed word
//   o_irq        timeout & interrupt-enable
module timer_channel
   import timer_multi_channel_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter int PRESC_W        = 8,
   parameter int DEFAULT_PERIOD = 49999
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wr_en,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_irq
);

   localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic             RST_ZERO   = (DEFAULT_PERIOD == 0) ? 1'b1 : 1'b0;

   logic [CNT_W-1:0]   r_period;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_snap;
   logic [PRESC_W-1:0] r_prescale;
   logic [PRESC_W-1:0] r_presc;
   logic               r_ie;
   logic               r_cont;
   logic               r_running;
   logic               r_timeout;
   logic               r_zero_d;

   logic               w_wr_status;
   logic               w_wr_ctrl;
   logic               w_wr_period;
   logic               w_wr_snap;
   logic               w_start;
   logic               w_stop;
   logic               w_tick;
   logic               w_zero;
   logic               w_event;
   logic [CNT_W-1:0]   w_new_period;

   assign w_wr_status  = i_wr_en & (i_offset == STATUS);
   assign w_wr_ctrl    = i_wr_en & (i_offset == CONTROL);
   assign w_wr_period  = i_wr_en & (i_offset == PERIOD);
   assign w_wr_snap    = i_wr_en & (i_offset == PRESC_SNAP);
   assign w_start      = w_wr_ctrl & i_wdata[CTL_START];
   assign w_stop       = w_wr_ctrl & i_wdata[CTL_STOP] & ~i_wdata[CTL_START];
   assign w_new_period = i_wdata[CNT_W-1:0];

   // >= rather than == so that lowering prescale mid-count cannot strand
   // the prescaler above its new terminal count.
   assign w_tick  = (r_presc >= r_prescale);
   assign w_zero  = (r_cnt == '0);
   assign w_event = w_zero & ~r_zero_d;

   assign o_irq = r_timeout & r_ie;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_period   <= RST_PERIOD;
         r_cnt      <= RST_PERIOD;
         r_snap     <= '0;
         r_prescale <= '0;
         r_presc    <= '0;
         r_ie       <= 1'b0;
         r_cont     <= 1'b0;
         r_running  <= 1'b0;
         r_timeout  <= 1'b0;
         r_zero_d   <= RST_ZERO;
      end else begin
         r_zero_d <= w_zero;

         // a timeout arriving with a status write wins
         if (w_event)
            r_timeout <= 1'b1;
         else if (w_wr_status)
            r_timeout <= 1'b0;

         if (w_wr_ctrl) begin
            r_ie   <= i_wdata[CTL_IE];
            r_cont <= i_wdata[CTL_CONT];
         end

         if (w_wr_snap) begin
            r_prescale <= i_wdata[PRESC_W-1:0];
            r_snap     <= r_cnt;
         end

         if (w_wr_period) begin
            r_period  <= w_new_period;
            r_cnt     <= w_new_period;
            r_presc   <= '0;
            r_running <= 1'b0;
            // loading a zero period is not itself a timeout
            r_zero_d  <= (w_new_period == '0);
         end else if (w_start) begin
            r_running <= 1'b1;
            r_presc   <= '0;
            // clearing the edge history lets a zero period fire once per start;
            // an expired one-shot restarts from a full period instead
            r_zero_d  <= 1'b0;
            if (w_zero)
               r_cnt <= r_period;
         end else if (w_stop) begin
            r_running <= 1'b0;
         end else if (r_running) begin
            if (w_tick) begin
               r_presc <= '0;
               if (w_zero) begin
                  if (r_cont)
                     r_cnt <= r_period;
                  else
                     r_running <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if ((r_cnt == CNT_W'(1)) && !r_cont)
                     r_running <= 1'b0;
               end
            end else begin
               r_presc <= r_presc + PRESC_W'(1);
            end
         end
      end
   end

   always_comb begin
      o_rdata = '0;
      case (i_offset)
         STATUS: begin
            o_rdata[ST_RUNNING] = r_running;
            o_rdata[ST_TIMEOUT] = r_timeout;
         end
         CONTROL: begin
            o_rdata[CTL_CONT] = r_cont;
            o_rdata[CTL_IE]   = r_ie;
         end
         PERIOD:  o_rdata[CNT_W-1:0] = r_period;
         default: o_rdata[CNT_W-1:0] = r_snap;
      endcase
   end

endmodule

// File: rtl/timer_multi_channel.sv
// Multi-channel interval timer: NUM_CH independent timer_channel blocks
// behind a single word-addressed register port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   address               {channel, word offset}
//   chipselect, write_n   write when chipselect & ~write_n, read when chipselect & write_n
//   writedata, readdata   32-bit data; readdata is registered (1-cycle latency)
//   irq, irq_any          per-channel interrupt and their OR
module timer_multi_channel
   import timer_multi_channel_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int CNT_W          = 32,
   parameter int PRESC_W        = 8,
   parameter int DEFAULT_PERIOD = 49999
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [$clog2(NUM_CH)+1:0]  address,
   input  logic                       chipselect,
   input  logic                       write_n,
   input  logic [31:0]                writedata,
   output logic [31:0]                readdata,
   output logic [NUM_CH-1:0]          irq,
   output logic                       irq_any
);

   localparam int CH_BITS = $clog2(NUM_CH);
   localparam int CH_W    = (CH_BITS > 0) ? CH_BITS : 1;

   logic [CH_W-1:0]   w_ch;
   logic              w_wr;
   logic              w_rd;
   logic [NUM_CH-1:0] w_sel;
   logic [31:0]       w_ch_rdata [NUM_CH];
   logic [31:0]       w_rd_mux;

   generate
      if (CH_BITS > 0) begin : g_ch_field
         assign w_ch = address[CH_BITS+1:2];
      end else begin : g_single_ch
         assign w_ch = '0;
      end
   endgenerate

   assign w_wr = chipselect & ~write_n;
   assign w_rd = chipselect & write_n;

   // channel numbers >= NUM_CH match no select: writes dropped, reads return 0
   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      assign w_sel[g] = (int'(w_ch) == g);

      timer_channel #(
         .CNT_W          (CNT_W),
         .PRESC_W        (PRESC_W),
         .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .i_wr_en  (w_wr & w_sel[g]),
         .i_offset (address[1:0]),
         .i_wdata  (writedata),
         .o_rdata  (w_ch_rdata[g]),
         .o_irq    (irq[g])
      );
   end

   assign irq_any = |irq;

   always_comb begin
      w_rd_mux = '0;
      for (int n = 0; n < NUM_CH; n++) begin
         if (w_sel[n])
            w_rd_mux = w_ch_rdata[n];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         readdata <= '0;
      else if (w_rd)
         readdata <= w_rd_mux;
   end

endmodule

// File: tb/tb_timer_multi_channel.sv
module tb_timer_multi_channel;
   import timer_multi_channel_pkg::*;

   localparam int NUM_CH         = 3;
   localparam int CNT_W          = 32;
   localparam int PRESC_W        = 8;
   localparam int DEFAULT_PERIOD = 49999;

   logic              clk;
   logic              reset;
   logic [3:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic [NUM_CH-1:0] irq;
   logic              irq_any;

   int n_pass;
   int n_total;

   typedef struct {
      logic        wr;
      logic [1:0]  ch;
      logic [1:0]  off;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   timer_multi_channel #(
      .NUM_CH         (NUM_CH),
      .CNT_W          (CNT_W),
      .PRESC_W        (PRESC_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .irq_any    (irq_any)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic wr(input logic [1:0] ch, input logic [1:0] off, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = {ch, off};
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] ch, input logic [1:0] off, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = {ch, off};
      @(posedge clk);
      #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      logic [31:0] d;
      n_pass     = 0;
      n_total    = 0;
      reset      = 1'b1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = '0;
      writedata  = '0;

      // register-level vectors: {wr, ch, off, data, expected read}
      vecs.push_back('{1'b0, 2'd0, STATUS,     32'd0,   32'd0});
      vecs.push_back('{1'b0, 2'd0, CONTROL,    32'd0,   32'd0});
      vecs.push_back('{1'b0, 2'd0, PERIOD,     32'd0,   32'd49999});
      vecs.push_back('{1'b0, 2'd1, PERIOD,     32'd0,   32'd49999});
      vecs.push_back('{1'b0, 2'd0, PRESC_SNAP, 32'd0,   32'd0});
      vecs.push_back('{1'b1, 2'd2, PERIOD,     32'd100, 32'd0});
      vecs.push_back('{1'b0, 2'd2, PERIOD,     32'd0,   32'd100});
      vecs.push_back('{1'b1, 2'd2, PRESC_SNAP, 32'd5,   32'd0});
      vecs.push_back('{1'b0, 2'd2, PRESC_SNAP, 32'd0,   32'd100});
      vecs.push_back('{1'b1, 2'd2, CONTROL,    32'd7,   32'd0});
      vecs.push_back('{1'b0, 2'd2, STATUS,     32'd0,   32'd2});
      vecs.push_back('{1'b0, 2'd2, CONTROL,    32'd0,   32'd3});
      vecs.push_back('{1'b1, 2'd2, CONTROL,    32'd8,   32'd0});
      vecs.push_back('{1'b0, 2'd2, STATUS,     32'd0,   32'd0});
      vecs.push_back('{1'b1, 2'd2, CONTROL,    32'd12,  32'd0});
      vecs.push_back('{1'b0, 2'd2, STATUS,     32'd0,   32'd2});
      vecs.push_back('{1'b0, 2'd2, CONTROL,    32'd0,   32'd0});
      vecs.push_back('{1'b1, 2'd3, PERIOD,     32'd7,   32'd0});
      vecs.push_back('{1'b0, 2'd3, PERIOD,     32'd0,   32'd0});
      vecs.push_back('{1'b0, 2'd3, STATUS,     32'd0,   32'd0});
      vecs.push_back('{1'b0, 2'd2, PERIOD,     32'd0,   32'd100});
      vecs.push_back('{1'b0, 2'd0, PERIOD,     32'd0,   32'd49999});
      vecs.push_back('{1'b1, 2'd2, PERIOD,     32'd100, 32'd0});
      vecs.push_back('{1'b0, 2'd2, STATUS,     32'd0,   32'd0});

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset irq", 32'(irq), 32'd0);
      chk("reset irq_any", 32'(irq_any), 32'd0);
      chk("reset readdata", readdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].wr) begin
            wr(vecs[i].ch, vecs[i].off, vecs[i].data);
         end else begin
            rd(vecs[i].ch, vecs[i].off, d);
            chk($sformatf("vec%0d ch%0d word%0d", i, vecs[i].ch, vecs[i].off), d, vecs[i].exp);
         end
      end

      // ch0 continuous, period 4, prescale 0: timeouts 5 and 10 cycles after start
      wr(2'd0, PERIOD, 32'd4);
      wr(2'd0, PRESC_SNAP, 32'd0);
      wr(2'd0, CONTROL, 32'd7);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ch0 irq cycle %0d", k), 32'(irq[0]), (k == 5) ? 32'd1 : 32'd0);
      end
      chk("ch0 irq_any cycle 5", 32'(irq_any), 32'd1);
      wr(2'd0, STATUS, 32'd0);
      chk("ch0 irq after clear", 32'(irq[0]), 32'd0);
      for (int k = 7; k <= 10; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("ch0 irq cycle %0d", k), 32'(irq[0]), (k == 10) ? 32'd1 : 32'd0);
      end

      // status clear on the same edge as a timeout event leaves timeout set
      wr(2'd0, PERIOD, 32'd4);
      wr(2'd0, STATUS, 32'd0);
      chk("ch0 irq before restart", 32'(irq[0]), 32'd0);
      wr(2'd0, CONTROL, 32'd7);
      repeat (4) @(posedge clk);
      wr(2'd0, STATUS, 32'd0);
      chk("clear collides with timeout", 32'(irq[0]), 32'd1);
      wr(2'd0, STATUS, 32'd0);
      chk("clear after collision", 32'(irq[0]), 32'd0);
      wr(2'd0, PERIOD, 32'd4);

      // ch1 one-shot, period 3, prescale 2: decrement every 3 cycles
      wr(2'd1, PERIOD, 32'd3);
      wr(2'd1, PRESC_SNAP, 32'd2);
      wr(2'd1, CONTROL, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i > 0)
            @(posedge clk);
         wr(2'd1, PRESC_SNAP, 32'd2);
         rd(2'd1, PRESC_SNAP, d);
         chk($sformatf("ch1 snapshot %0d", i), d, 32'(3 - i));
      end
      rd(2'd1, STATUS, d);
      chk("ch1 status after 12 cycles", d, 32'd1);
      chk("ch1 irq masked", 32'(irq[1]), 32'd0);
      chk("irq_any all masked/clear", 32'(irq_any), 32'd0);
      rd(2'd0, STATUS, d);
      chk("ch0 status unaffected", d, 32'd0);
      rd(2'd0, PERIOD, d);
      chk("ch0 period unaffected", d, 32'd4);

      // period 0: counter held at 0, one timeout per start
      wr(2'd1, PERIOD, 32'd0);
      wr(2'd1, STATUS, 32'd0);
      repeat (3) @(posedge clk);
      rd(2'd1, STATUS, d);
      chk("ch1 zero period load no timeout", d, 32'd0);
      wr(2'd1, CONTROL, 32'd6);
      repeat (2) @(posedge clk);
      rd(2'd1, STATUS, d);
      chk("ch1 zero period start timeout", d, 32'd3);
      wr(2'd1, STATUS, 32'd0);
      repeat (5) @(posedge clk);
      rd(2'd1, STATUS, d);
      chk("ch1 zero period single timeout", d, 32'd2);
      wr(2'd1, CONTROL, 32'd8);

      // period write while running reloads counter and stops
      wr(2'd2, CONTROL, 32'd4);
      repeat (8) @(posedge clk);
      rd(2'd2, STATUS, d);
      chk("ch2 running before period write", d, 32'd2);
      wr(2'd2, PERIOD, 32'd10);
      wr(2'd2, PRESC_SNAP, 32'd0);
      rd(2'd2, PRESC_SNAP, d);
      chk("ch2 snapshot after period write", d, 32'd10);
      rd(2'd2, STATUS, d);
      chk("ch2 stopped by period write", d, 32'd0);

      // asynchronous reset mid-count
      wr(2'd0, STATUS, 32'd0);
      wr(2'd0, CONTROL, 32'd7);
      repeat (6) @(posedge clk);
      #1;
      chk("ch0 irq before async reset", 32'(irq[0]), 32'd1);
      rd(2'd0, PERIOD, d);
      chk("ch0 period before async reset", d, 32'd4);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset irq", 32'(irq), 32'd0);
      chk("async reset irq_any", 32'(irq_any), 32'd0);
      chk("async reset readdata", readdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      wr(2'd0, PRESC_SNAP, 32'd0);
      rd(2'd0, PRESC_SNAP, d);
      chk("ch0 counter after reset", d, 32'd49999);
      rd(2'd0, PERIOD, d);
      chk("ch0 period after reset", d, 32'd49999);
      rd(2'd0, CONTROL, d);
      chk("ch0 control after reset", d, 32'd0);
      rd(2'd2, PERIOD, d);
      chk("ch2 period after reset", d, 32'd49999);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
